// File: rtl/gpu_pkg.sv
// gpu_pkg: encodings and widths shared by the fetcher, decoder and scheduler
package gpu_pkg;
  localparam int ADDR_BITS  = 8;
  localparam int DATA_BITS  = 16;
  localparam int INDEX_BITS = 3;
  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;
  typedef enum logic [2:0] {
    FETCH_IDLE     = 3'b000,
    FETCH_FETCHING = 3'b001,
    FETCH_FETCHED  = 3'b010
  } fetch_state_t;
endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped instruction store, one instruction per line
//   clk, rst_n        : clock, async active-low reset (clears valid bits)
//   i_rd_index/i_rd_tag -> o_hit, o_rd_data : combinational lookup
//   i_wr_en/i_wr_index/i_wr_tag/i_wr_data   : synchronous line fill
//   i_flush           : invalidate every line at the next edge
module icache_array
  import gpu_pkg::*;
#(
  parameter int INDEX_BITS_P = INDEX_BITS,
  parameter int TAG_BITS_P   = ADDR_BITS - INDEX_BITS,
  parameter int DATA_BITS_P  = DATA_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INDEX_BITS_P-1:0] i_rd_index,
  input  logic [TAG_BITS_P-1:0]   i_rd_tag,
  output logic                    o_hit,
  output logic [DATA_BITS_P-1:0]  o_rd_data,
  input  logic                    i_wr_en,
  input  logic [INDEX_BITS_P-1:0] i_wr_index,
  input  logic [TAG_BITS_P-1:0]   i_wr_tag,
  input  logic [DATA_BITS_P-1:0]  i_wr_data,
  input  logic                    i_flush
);
  localparam int LINES = 1 << INDEX_BITS_P;
  logic [LINES-1:0]       r_valid;
  logic [TAG_BITS_P-1:0]  r_tag  [LINES];
  logic [DATA_BITS_P-1:0] r_data [LINES];
  // flush wins over a coincident fill so the filled line stays invalid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_valid <= '0;
    else if (i_flush) r_valid <= '0;
    else if (i_wr_en) r_valid[i_wr_index] <= 1'b1;
  always_ff @(posedge clk)
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  assign o_hit     = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
  assign o_rd_data = r_data[i_rd_index];
endmodule

// File: rtl/icache_fetcher.sv
// icache_fetcher: fetch stage delivering the instruction at current_pc via a small icache
//   clk, reset                      : clock, async active-low reset
//   core_state, current_pc, flush   : core control inputs
//   mem_read_valid/address/ready/data : program-memory read handshake
//   fetcher_state, instruction      : fetch status and registered instruction
module icache_fetcher
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = ADDR_BITS,
  parameter int PROGRAM_MEM_DATA_BITS = DATA_BITS,
  parameter int CACHE_INDEX_BITS      = INDEX_BITS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);
  localparam int A = PROGRAM_MEM_ADDR_BITS;
  localparam int D = PROGRAM_MEM_DATA_BITS;
  localparam int I = CACHE_INDEX_BITS;
  fetch_state_t r_state, w_state;
  logic         r_valid, w_valid;
  logic [A-1:0] r_addr, w_addr;
  logic [D-1:0] r_instr, w_instr;
  logic         w_hit, w_fill;
  logic [D-1:0] w_line;
  // the fill is indexed by the latched request address, not the live PC
  icache_array #(.INDEX_BITS_P(I), .TAG_BITS_P(A - I), .DATA_BITS_P(D)) u_array (
    .clk        (clk),
    .rst_n      (reset),
    .i_rd_index (current_pc[I-1:0]),
    .i_rd_tag   (current_pc[A-1:I]),
    .o_hit      (w_hit),
    .o_rd_data  (w_line),
    .i_wr_en    (w_fill),
    .i_wr_index (r_addr[I-1:0]),
    .i_wr_tag   (r_addr[A-1:I]),
    .i_wr_data  (mem_read_data),
    .i_flush    (flush)
  );
  always_comb begin
    w_state = r_state;
    w_valid = r_valid;
    w_addr  = r_addr;
    w_instr = r_instr;
    w_fill  = 1'b0;
    case (r_state)
      FETCH_IDLE:
        if (core_state == CORE_FETCH) begin
          if (w_hit && !flush) begin
            w_instr = w_line;
            w_state = FETCH_FETCHED;
          end else begin
            w_valid = 1'b1;
            w_addr  = current_pc;
            w_state = FETCH_FETCHING;
          end
        end
      FETCH_FETCHING:
        if (mem_read_ready) begin
          w_instr = mem_read_data;
          w_valid = 1'b0;
          w_fill  = 1'b1;
          w_state = FETCH_FETCHED;
        end
      FETCH_FETCHED: w_state = (core_state == CORE_DECODE) ? FETCH_IDLE : FETCH_FETCHED;
      default: w_state = FETCH_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= FETCH_IDLE;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_state;
      r_valid <= w_valid;
      r_addr  <= w_addr;
      r_instr <= w_instr;
    end
  assign mem_read_valid   = r_valid;
  assign mem_read_address = r_addr;
  assign fetcher_state    = r_state;
  assign instruction      = r_instr;
endmodule

// File: tb/tb_icache_fetcher.sv
// tb_icache_fetcher: directed self-checking bench for icache_fetcher
module tb_icache_fetcher;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  core_state = 3'b000;
  logic [7:0]  current_pc = 8'h00;
  logic        flush = 1'b0;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready = 1'b0;
  logic [15:0] mem_read_data = 16'h0000;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [2:0] C_IDLE = 3'b000, C_FETCH = 3'b001, C_DECODE = 3'b010, C_WAIT = 3'b100;
  localparam logic [2:0] S_IDLE = 3'b000, S_FETCHING = 3'b001, S_FETCHED = 3'b010;
  icache_fetcher dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .flush            (flush),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic [2:0] st, input logic v, input logic [7:0] a, input logic [15:0] ins);
    chk({tag, ".state"}, 32'(fetcher_state), 32'(st));
    chk({tag, ".valid"}, 32'(mem_read_valid), 32'(v));
    chk({tag, ".addr"}, 32'(mem_read_address), 32'(a));
    chk({tag, ".instr"}, 32'(instruction), 32'(ins));
  endtask
  task automatic fill(input logic [15:0] d);
    mem_read_ready = 1'b1;
    mem_read_data  = d;
    core_state     = C_WAIT;
    tick;
    mem_read_ready = 1'b0;
  endtask
  task automatic decode;
    core_state = C_DECODE;
    tick;
    core_state = C_IDLE;
  endtask
  initial begin
    mem_read_ready = 1'b1;
    core_state = C_FETCH;
    repeat (3) tick;
    chk_out("reset", S_IDLE, 1'b0, 8'h00, 16'h0000);
    mem_read_ready = 1'b0;
    core_state = C_IDLE;
    reset = 1'b1;
    tick;
    chk_out("idle_hold", S_IDLE, 1'b0, 8'h00, 16'h0000);
    current_pc = 8'h05;
    core_state = C_FETCH;
    tick;
    chk_out("cold_req", S_FETCHING, 1'b1, 8'h05, 16'h0000);
    current_pc = 8'h66;
    core_state = C_WAIT;
    tick;
    chk_out("cold_wait1", S_FETCHING, 1'b1, 8'h05, 16'h0000);
    tick;
    chk_out("cold_wait2", S_FETCHING, 1'b1, 8'h05, 16'h0000);
    fill(16'h3123);
    chk_out("cold_done", S_FETCHED, 1'b0, 8'h05, 16'h3123);
    core_state = C_WAIT;
    tick;
    chk_out("fetched_hold", S_FETCHED, 1'b0, 8'h05, 16'h3123);
    decode;
    chk_out("cold_decode", S_IDLE, 1'b0, 8'h05, 16'h3123);
    current_pc = 8'h05;
    core_state = C_FETCH;
    tick;
    chk_out("hit_05", S_FETCHED, 1'b0, 8'h05, 16'h3123);
    decode;
    current_pc = 8'h0D;
    core_state = C_FETCH;
    tick;
    chk_out("conf_req_0d", S_FETCHING, 1'b1, 8'h0D, 16'h3123);
    fill(16'h9A07);
    chk_out("conf_done_0d", S_FETCHED, 1'b0, 8'h0D, 16'h9A07);
    decode;
    current_pc = 8'h05;
    core_state = C_FETCH;
    tick;
    chk_out("conf_miss_05", S_FETCHING, 1'b1, 8'h05, 16'h9A07);
    fill(16'h3123);
    decode;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    current_pc = 8'h05;
    core_state = C_FETCH;
    tick;
    chk_out("flush_miss_05", S_FETCHING, 1'b1, 8'h05, 16'h3123);
    fill(16'h3123);
    decode;
    current_pc = 8'h0D;
    core_state = C_FETCH;
    tick;
    chk_out("flush_miss_0d", S_FETCHING, 1'b1, 8'h0D, 16'h3123);
    fill(16'h9A07);
    decode;
    current_pc = 8'h0D;
    core_state = C_FETCH;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk_out("flush_lookup", S_FETCHING, 1'b1, 8'h0D, 16'h9A07);
    fill(16'h9A07);
    decode;
    current_pc = 8'h02;
    core_state = C_FETCH;
    tick;
    chk_out("fl_fill_req", S_FETCHING, 1'b1, 8'h02, 16'h9A07);
    flush = 1'b1;
    fill(16'h1234);
    flush = 1'b0;
    chk_out("fl_fill_done", S_FETCHED, 1'b0, 8'h02, 16'h1234);
    decode;
    current_pc = 8'h02;
    core_state = C_FETCH;
    tick;
    chk_out("fl_fill_miss", S_FETCHING, 1'b1, 8'h02, 16'h1234);
    fill(16'h1234);
    decode;
    current_pc = 8'h02;
    core_state = C_FETCH;
    tick;
    chk_out("refill_hit", S_FETCHED, 1'b0, 8'h02, 16'h1234);
    decode;
    current_pc = 8'h07;
    core_state = C_FETCH;
    tick;
    chk_out("rst_req_07", S_FETCHING, 1'b1, 8'h07, 16'h1234);
    core_state = C_IDLE;
    #2 reset = 1'b0;
    #1;
    chk_out("async_rst", S_IDLE, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    mem_read_ready = 1'b1;
    mem_read_data = 16'hBEEF;
    tick;
    tick;
    chk_out("post_rst_ready", S_IDLE, 1'b0, 8'h00, 16'h0000);
    mem_read_ready = 1'b0;
    current_pc = 8'h02;
    core_state = C_FETCH;
    tick;
    chk_out("post_rst_miss", S_FETCHING, 1'b1, 8'h02, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/icache_fetcher.md
Name: icache_fetcher

Overview:
- Per-core instruction fetch stage, directly upstream of the decoder.
- During the core FETCH state it delivers the 16-bit instruction at the current PC. The instruction is held stable through DECODE so the decoder can sample it.
- A small direct-mapped instruction cache, one instruction per line, sits in front of the shared program-memory controller.
- Hits complete in 1 cycle. Misses use the program-memory valid/ready handshake and fill the line.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8: PC and program-memory address width.
- PROGRAM_MEM_DATA_BITS, 16: instruction width.
- CACHE_INDEX_BITS, 3: log2 of line count (default 8 lines). Tag width = PROGRAM_MEM_ADDR_BITS - CACHE_INDEX_BITS.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low (0 = in reset)
- core_state  in  3  core FSM state: 000 IDLE, 001 FETCH, 010 DECODE, 011 REQUEST, 100 WAIT, 101 EXECUTE, 110 UPDATE, 111 DONE
- current_pc  in  8  PC to fetch
- flush  in  1  invalidate all lines (kernel launch / program reload)
- mem_read_valid  out  1  program-memory read request
- mem_read_address  out  8  request address
- mem_read_ready  in  1  read data valid / request accepted
- mem_read_data  in  16  returned instruction
- fetcher_state  out  3  000 IDLE, 001 FETCHING, 010 FETCHED
- instruction  out  16  fetched instruction, registered

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0.
  - All line valid bits cleared. Tag and data contents are don't-care.
- Lookup fields: index = current_pc[CACHE_INDEX_BITS-1:0]; tag = current_pc[7:CACHE_INDEX_BITS].
- IDLE:
  - Acts only when core_state==FETCH. Otherwise it holds all outputs.
  - Hit (line valid, tag match, no flush this cycle): instruction<=line data; next state FETCHED. Latency 1 cycle; mem_read_valid stays 0.
  - Miss (or flush asserted this cycle): mem_read_valid<=1, mem_read_address<=current_pc; next state FETCHING.
- FETCHING:
  - mem_read_valid and mem_read_address are held stable until the cycle mem_read_ready=1.
  - In that cycle: instruction<=mem_read_data, mem_read_valid<=0, line[index] <= {valid=1, tag, data}; next state FETCHED.
  - Zero-wait response is allowed: ready arriving in the first FETCHING cycle completes the fetch.
- FETCHED:
  - instruction is held.
  - On core_state==DECODE, go to IDLE. The decoder samples during that same DECODE cycle.
  - The instruction register keeps its value after leaving FETCHED.
- mem_read_ready is ignored outside FETCHING.
- current_pc is sampled only in the IDLE lookup cycle. Changes during FETCHING have no effect.
- flush:
  - Clears every valid bit at the next edge, in any state.
  - Flush in the same cycle as a miss fill: the fill is discarded (line left invalid), but the instruction is still delivered and the state still goes to FETCHED.
  - Flush never aborts an outstanding request.
- Reset mid-FETCHING: mem_read_valid drops asynchronously, there is no outstanding request afterwards, and later ready pulses are ignored.
- Only one request is ever outstanding. No speculative or next-line prefetch.

Decomposition:
- Shared package gpu_pkg:
  - core_state encodings (CORE_IDLE..CORE_DONE), reused by the decoder and scheduler.
  - fetcher_state encodings.
  - Address/data width constants.
- Sub-module icache_array:
  - valid/tag/data storage.
  - Combinational read by index producing hit and data.
  - Single synchronous write port.
  - Synchronous flush of all valid bits.
  - Async active-low reset clears valid bits.
- icache_fetcher holds the FSM and handshake only.

Test Plan:
- Reset: hold reset=0, toggle clk, then drive mem_read_ready=1 -> mem_read_valid=0, address=0, instruction=0x0000, fetcher_state=000.
- Cold miss: pc=0x05, core_state=FETCH; ready after 3 cycles with data 0x3123 -> valid=1 and addr=0x05 stable for 3 cycles. Then instruction=0x3123, state FETCHED, valid=0; DECODE returns state to IDLE.
- Hit: refetch pc=0x05 -> FETCHED one cycle after FETCH, instruction=0x3123, mem_read_valid never asserted.
- Conflict: fetch pc=0x0D (index 5, tag 1), data 0x9A07 -> miss and fill. Refetch pc=0x05 -> miss again with mem_read_address=0x05.
- Flush: flush pulse, then pc=0x0D -> miss. Separately, flush coincident with a fill of pc=0x02 -> instruction still delivered, but the next fetch of 0x02 misses.
- Async reset mid-FETCHING (pc=0x07) -> mem_read_valid=0 with no clock edge, state IDLE. A ready pulse after release leaves instruction unchanged.
